// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display scanner with double-buffered value,
// leading-zero blanking and decimal or hex glyphs.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   load        one-cycle strobe capturing load_value/load_dp
//   load_value  one nibble per digit, digit 0 least significant
//   load_dp     decimal point per digit
//   lzb         leading-zero blanking enable (live)
//   seg         segments {a,b,c,d,e,f,g}, active-high
//   dp          decimal point of the driven digit
//   digit_en    one-hot enable of the driven digit
//   pending     a loaded value waits for the frame boundary
//   frame_done  one-cycle pulse after the last digit of a frame
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lzb,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam bit HEX = (HEX_MODE != 0);

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_DIGITS - 1);

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = HEX ? 7'b1110111 : 7'b0000001;
      4'hB: g = HEX ? 7'b0011111 : 7'b0000001;
      4'hC: g = HEX ? 7'b1001110 : 7'b0000001;
      4'hD: g = HEX ? 7'b0111101 : 7'b0000001;
      4'hE: g = HEX ? 7'b1001111 : 7'b0000001;
      4'hF: g = HEX ? 7'b1000111 : 7'b0000001;
    endcase
    return g;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fd_q, fd_d;
  logic                  pend_q, pend_d;
  logic [VW-1:0]         act_v_q, act_v_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [VW-1:0]         sh_v_q, sh_v_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;

  logic                  tick;
  logic                  last;
  logic                  swap;
  logic [NUM_DIGITS-1:0] blank;
  logic                  hi_zero;
  logic [3:0]            nib;
  logic                  sel_dp;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] en_sel;

  // Blanking walks down from the most significant digit; a digit is
  // blanked only while every nibble above and including it is zero.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (act_v_q[4*k +: 4] == 4'h0);
      if (k != 0) blank[k] = lzb & hi_zero;
    end
  end

  always_comb begin
    nib       = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    en_sel    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (ptr_q == PW'(k)) begin
        nib       = act_v_q[4*k +: 4];
        sel_dp    = act_dp_q[k];
        sel_blank = blank[k];
        en_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    tick = (cnt_q == CNT_LAST);
    last = (ptr_q == PTR_LAST);
    swap = tick & last;

    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    ptr_d    = ptr_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    en_d     = en_q;
    fd_d     = swap;
    pend_d   = pend_q;
    act_v_d  = act_v_q;
    act_dp_d = act_dp_q;
    sh_v_d   = sh_v_q;
    sh_dp_d  = sh_dp_q;

    if (tick) begin
      ptr_d = last ? '0 : ptr_q + 1'b1;
      seg_d = sel_blank ? 7'b0 : glyph(nib);
      dp_d  = sel_dp;
      en_d  = en_sel;
    end

    // The active value only changes at the frame boundary; a load that
    // lands on that boundary bypasses the shadow entirely.
    if (swap) begin
      if (load) begin
        act_v_d  = load_value;
        act_dp_d = load_dp;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        act_v_d  = sh_v_q;
        act_dp_d = sh_dp_q;
        pend_d   = 1'b0;
      end
    end else if (load) begin
      sh_v_d  = load_value;
      sh_dp_d = load_dp;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      ptr_q    <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      en_q     <= '0;
      fd_q     <= 1'b0;
      pend_q   <= 1'b0;
      act_v_q  <= '0;
      act_dp_q <= '0;
      sh_v_q   <= '0;
      sh_dp_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      fd_q     <= fd_d;
      pend_q   <= pend_d;
      act_v_q  <= act_v_d;
      act_dp_q <= act_dp_d;
      sh_v_q   <= sh_v_d;
      sh_dp_q  <= sh_dp_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = en_q;
  assign pending    = pend_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Testbench for seven_segment_scanner: decimal and hex instances driven
// in parallel and checked against a cycle-count based reference model.
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] load_value;
  logic [3:0]  load_dp;
  logic        lzb;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] en0, en1;
  logic       pend0, pend1;
  logic       fd0, fd1;

  seven_segment_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .load(load),
    .load_value(load_value), .load_dp(load_dp), .lzb(lzb),
    .seg(seg0), .dp(dp0), .digit_en(en0),
    .pending(pend0), .frame_done(fd0)
  );

  seven_segment_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .load(load),
    .load_value(load_value), .load_dp(load_dp), .lzb(lzb),
    .seg(seg1), .dp(dp1), .digit_en(en1),
    .pending(pend1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [6:0] dec_t[16];
  logic [6:0] hex_t[16];

  // reference model state
  int          m_n;
  logic [15:0] m_av, m_sv;
  logic [3:0]  m_ad, m_sd;
  logic        m_p;
  logic [6:0]  e_s0, e_s1;
  logic        e_dp;
  logic [3:0]  e_en;
  logic        e_fd;
  int          m_fdc;

  // observations
  logic [6:0] cap0[4];
  logic [6:0] cap1[4];
  logic       capdp[4];
  int         fd_cnt;
  bit         saw_one;
  bit         saw_pend;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  ldp;
    logic        lz;
    logic [27:0] dec;
    logic [27:0] hex;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_edge();
    int d;
    int v;
    bit tk;
    if (reset) begin
      m_n  = 0;
      m_av = '0; m_ad = '0;
      m_sv = '0; m_sd = '0;
      m_p  = 1'b0;
      e_s0 = '0; e_s1 = '0;
      e_dp = 1'b0; e_en = '0; e_fd = 1'b0;
    end else begin
      m_n++;
      e_fd = 1'b0;
      tk = (m_n % RD == 0);
      d = tk ? ((m_n / RD) - 1) % ND : -1;
      if (tk) begin
        v = int'((m_av >> (4 * d)) & 16'hF);
        if (lzb && d != 0 && (m_av >> (4 * d)) == 16'h0) begin
          e_s0 = '0; e_s1 = '0;
        end else begin
          e_s0 = dec_t[v]; e_s1 = hex_t[v];
        end
        e_dp = m_ad[d];
        e_en = 4'(1 << d);
        e_fd = (d == ND - 1);
        if (e_fd) m_fdc++;
      end
      if (tk && d == ND - 1) begin
        if (load) begin
          m_av = load_value; m_ad = load_dp; m_p = 1'b0;
        end else if (m_p) begin
          m_av = m_sv; m_ad = m_sd; m_p = 1'b0;
        end
      end else if (load) begin
        m_sv = load_value; m_sd = load_dp; m_p = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("dec_outputs", {seg0, dp0, en0, pend0, fd0},
        {e_s0, e_dp, e_en, m_p, e_fd});
    chk("hex_outputs", {seg1, dp1, en1, pend1, fd1},
        {e_s1, e_dp, e_en, m_p, e_fd});
    for (int k = 0; k < 4; k++) begin
      if (en0 == 4'(1 << k)) begin
        cap0[k]  = seg0;
        cap1[k]  = seg1;
        capdp[k] = dp0;
      end
    end
    if (fd0) fd_cnt++;
    if (seg0 == 7'b0110000) saw_one = 1'b1;
    if (pend0) saw_pend = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; load_value = v; load_dp = d;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    dec_t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
              7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
    hex_t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    vecs[0] = '{16'h1234, 4'b0100, 1'b0,
      {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011},
      {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1,
      {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110},
      {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}};
    vecs[2] = '{16'h0000, 4'b1000, 1'b1,
      {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110},
      {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
    vecs[3] = '{16'hABCD, 4'b0000, 1'b0,
      {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001},
      {7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101}};
    vecs[4] = '{16'h9876, 4'b1010, 1'b0,
      {7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111},
      {7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111}};
    vecs[5] = '{16'hE0F5, 4'b1001, 1'b1,
      {7'b0000001, 7'b1111110, 7'b0000001, 7'b1011011},
      {7'b1001111, 7'b1111110, 7'b1000111, 7'b1011011}};
    vecs[6] = '{16'h0800, 4'b0001, 1'b1,
      {7'b0000000, 7'b1111111, 7'b1111110, 7'b1111110},
      {7'b0000000, 7'b1111111, 7'b1111110, 7'b1111110}};

    m_fdc = 0; fd_cnt = 0;
    saw_one = 1'b0; saw_pend = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cap0[k] = '0; cap1[k] = '0; capdp[k] = 1'b0;
    end

    reset = 1'b1; load = 1'b0; lzb = 1'b0;
    load_value = '0; load_dp = '0;
    cycle();
    cycle();
    chk("reset_state", {seg0, dp0, en0, pend0, fd0, seg1}, 32'h0);
    reset = 1'b0;

    // idle scan after reset
    repeat (3) cycle();
    chk("idle_blank", {en0, seg0}, 32'h0);
    cycle();
    chk("first_digit", {en0, seg0}, {4'b0001, 7'b1111110});
    for (int i = 1; i < 4; i++) begin
      repeat (4) cycle();
      chk("scan_order", {en0, seg0}, {4'(1 << i), 7'b1111110});
    end

    // table of loaded values, each observed over a full later frame
    repeat (2) cycle();
    for (int i = 0; i < 7; i++) begin
      lzb = vecs[i].lz;
      fd_cnt = 0; m_fdc = 0;
      do_load(vecs[i].val, vecs[i].ldp);
      if (i == 0) chk("pending_after_load", pend0, 1'b1);
      repeat (35) cycle();
      if (i == 0) chk("frame_done_count", fd_cnt, 2);
      chk("frame_done_model", fd_cnt, m_fdc);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d_dec_d%0d", i, k), cap0[k], vecs[i].dec[7*k +: 7]);
        chk($sformatf("v%0d_hex_d%0d", i, k), cap1[k], vecs[i].hex[7*k +: 7]);
        chk($sformatf("v%0d_dp_d%0d", i, k), capdp[k], vecs[i].ldp[k]);
      end
    end
    lzb = 1'b0;

    // two loads in one frame: only the later one is ever shown
    g = 0;
    while (m_n % FR != 1 && g < 20) begin cycle(); g++; end
    chk("align_early", (m_n % FR == 1), 1'b1);
    do_load(16'h1111, 4'b0000);
    cycle();
    saw_one = 1'b0;
    do_load(16'h2222, 4'b0000);
    repeat (36) cycle();
    chk("overwrite_never_1111", saw_one, 1'b0);
    for (int k = 0; k < 4; k++)
      chk("overwrite_2222", cap0[k], 7'b1101101);

    // load exactly on the frame-boundary tick
    g = 0;
    while ((m_n + 1) % FR != 0 && g < 20) begin cycle(); g++; end
    chk("align_swap", ((m_n + 1) % FR == 0), 1'b1);
    saw_pend = 1'b0;
    do_load(16'h3333, 4'b0000);
    chk("swap_load_no_pending", pend0, 1'b0);
    repeat (20) cycle();
    chk("swap_load_pending_never", saw_pend, 1'b0);
    for (int k = 0; k < 4; k++)
      chk("swap_load_3333", cap0[k], 7'b1111001);

    // reset mid-frame together with a load
    repeat (6) cycle();
    reset = 1'b1;
    load = 1'b1; load_value = 16'h7777; load_dp = 4'b1111;
    cycle();
    load = 1'b0; reset = 1'b0;
    chk("reset_mid_outputs", {seg0, dp0, en0, pend0, fd0, seg1, dp1, en1},
        32'h0);
    repeat (3) cycle();
    chk("reset_mid_idle", {en0, seg0}, 32'h0);
    cycle();
    chk("reset_mid_restart", {en0, seg0, dp0},
        {4'b0001, 7'b1111110, 1'b0});

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 9) == 0);
      load_value = 16'($urandom >> $urandom_range(16, 31));
      load_dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lzb = 1'($urandom);
      cycle();
    end
    reset = 1'b0; load = 1'b0;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
